// File: rtl/noc_wh_router.sv
`default_nettype none
// ============================================================================
//  Module   : noc_wh_router
//  Purpose  : 5-port wormhole mesh router. Per-input flit FIFOs, XY
//             dimension-order routing on head flits, per-output round-robin
//             arbitration with packet-level locking, valid/ready flow control.
//             Ports: 0=L, 1=E(+x), 2=W(-x), 3=N(+y), 4=S(-y).
//  Revision : 1.0 - initial release
// ============================================================================
module noc_wh_router #(
    parameter int DATA_WIDTH  = 512,
    parameter int FIFO_DEPTH  = 4,
    parameter int COORD_W     = 4,
    parameter int MY_X        = 0,
    parameter int MY_Y        = 0,
    parameter int CONG_THRESH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*DATA_WIDTH-1:0] in_data,
    input  logic [4:0]              in_last,
    input  logic [4:0]              in_valid,
    output logic [4:0]              in_ready,
    output logic [5*DATA_WIDTH-1:0] out_data,
    output logic [4:0]              out_last,
    output logic [4:0]              out_valid,
    input  logic [4:0]              out_ready,
    output logic [4:0]              cong_status,
    output logic [4:0]              err_uturn
);
    localparam int NP = 5;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [COORD_W-1:0] SELF_X = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] SELF_Y = COORD_W'(MY_Y);

    typedef enum logic {IN_HEAD = 1'b0, IN_BODY = 1'b1} in_state_e;
    typedef enum logic {OUT_UNLOCKED = 1'b0, OUT_LOCKED = 1'b1} out_state_e;

    // FIFO storage: each entry is {last, data}
    logic [DATA_WIDTH:0] mem_q  [NP][FIFO_DEPTH];
    logic [PW-1:0]       wptr_q [NP];
    logic [PW-1:0]       rptr_q [NP];
    logic [CW-1:0]       cnt_q  [NP];

    in_state_e  in_st_q  [NP];
    in_state_e  in_st_d  [NP];
    out_state_e out_st_q [NP];
    out_state_e out_st_d [NP];
    logic [2:0] owner_q  [NP];
    logic [2:0] owner_d  [NP];
    logic [2:0] rr_q     [NP];
    logic [2:0] rr_d     [NP];
    logic [NP-1:0] cong_q;
    logic [NP-1:0] uturn_q;

    logic [DATA_WIDTH:0] head [NP];
    logic [2:0]          route [NP];
    logic [NP-1:0]       empty;
    logic [NP-1:0]       full;
    logic [NP-1:0]       push;
    logic [NP-1:0]       pop;
    logic [NP-1:0]       uturn;
    logic [NP-1:0]       uturn_set;
    logic [COORD_W-1:0]  dst_x;
    logic [COORD_W-1:0]  dst_y;
    logic [2:0]          raw_route;

    // FIFO status, XY route of each FIFO head, U-turn folding back to L
    always_comb begin
        dst_x     = '0;
        dst_y     = '0;
        raw_route = 3'd0;
        for (int i = 0; i < NP; i++) begin
            head[i]  = mem_q[i][rptr_q[i]];
            empty[i] = (cnt_q[i] == '0);
            full[i]  = (cnt_q[i] == CW'(FIFO_DEPTH));
            push[i]  = in_valid[i] && !full[i];
            dst_x    = head[i][COORD_W-1:0];
            dst_y    = head[i][2*COORD_W-1:COORD_W];
            if (dst_x > SELF_X)      raw_route = 3'd1;
            else if (dst_x < SELF_X) raw_route = 3'd2;
            else if (dst_y > SELF_Y) raw_route = 3'd3;
            else if (dst_y < SELF_Y) raw_route = 3'd4;
            else                     raw_route = 3'd0;
            uturn[i]     = (raw_route == 3'(i)) && (i != 0);
            route[i]     = uturn[i] ? 3'd0 : raw_route;
            uturn_set[i] = uturn[i] && !empty[i] && (in_st_q[i] == IN_HEAD);
        end
    end

    // Output arbitration / locking and input HEAD/BODY next state
    always_comb begin
        logic       found;
        logic [2:0] gidx;
        int         j;
        found     = 1'b0;
        gidx      = 3'd0;
        j         = 0;
        out_data  = '0;
        out_last  = '0;
        out_valid = '0;
        pop       = '0;
        for (int i = 0; i < NP; i++) begin
            in_st_d[i]  = in_st_q[i];
            out_st_d[i] = out_st_q[i];
            owner_d[i]  = owner_q[i];
            rr_d[i]     = rr_q[i];
        end
        for (int o = 0; o < NP; o++) begin
            if (out_st_q[o] == OUT_LOCKED) begin
                out_valid[o] = !empty[owner_q[o]];
                if (out_valid[o]) begin
                    out_data[o*DATA_WIDTH +: DATA_WIDTH] = head[owner_q[o]][DATA_WIDTH-1:0];
                    out_last[o] = head[owner_q[o]][DATA_WIDTH];
                end
                if (out_valid[o] && out_ready[o]) begin
                    pop[owner_q[o]] = 1'b1;
                    if (head[owner_q[o]][DATA_WIDTH]) begin
                        out_st_d[o]         = OUT_UNLOCKED;
                        in_st_d[owner_q[o]] = IN_HEAD;
                    end
                end
            end else begin
                found = 1'b0;
                gidx  = 3'd0;
                for (int k = 0; k < NP; k++) begin
                    j = int'(rr_q[o]) + k;
                    if (j >= NP) j = j - NP;
                    if (!found && in_st_q[j] == IN_HEAD && !empty[j] && route[j] == 3'(o)) begin
                        found = 1'b1;
                        gidx  = 3'(j);
                    end
                end
                if (found) begin
                    out_st_d[o]   = OUT_LOCKED;
                    owner_d[o]    = gidx;
                    rr_d[o]       = (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
                    in_st_d[gidx] = IN_BODY;
                end
            end
        end
    end

    // FIFO payload write (storage needs no reset; pointers define validity)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (push[i]) mem_q[i][wptr_q[i]] <= {in_last[i], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    // FIFO pointers/counts and all control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                wptr_q[i]   <= '0;
                rptr_q[i]   <= '0;
                cnt_q[i]    <= '0;
                in_st_q[i]  <= IN_HEAD;
                out_st_q[i] <= OUT_UNLOCKED;
                owner_q[i]  <= 3'd0;
                rr_q[i]     <= 3'd0;
            end
            cong_q  <= '0;
            uturn_q <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
                if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
                cnt_q[i]    <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
                cong_q[i]   <= (cnt_q[i] >= CW'(CONG_THRESH));
                in_st_q[i]  <= in_st_d[i];
                out_st_q[i] <= out_st_d[i];
                owner_q[i]  <= owner_d[i];
                rr_q[i]     <= rr_d[i];
            end
            uturn_q <= uturn_q | uturn_set;
        end
    end

    assign in_ready    = ~full;
    assign cong_status = cong_q;
    assign err_uturn   = uturn_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_wh_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_wh_router
//  Purpose  : Self-checking bench for noc_wh_router (MY_X=1, MY_Y=1):
//             directed scenarios plus randomized traffic against a packet-level
//             scoreboard (per-source flit queues, no-interleave tracking).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_noc_wh_router;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5*DW-1:0] in_data;
    logic [4:0]    in_last, in_valid, in_ready;
    logic [5*DW-1:0] out_data;
    logic [4:0]    out_last, out_valid, out_ready, cong_status, err_uturn;

    int n_checks = 0;
    int n_pass   = 0;

    noc_wh_router #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(4), .COORD_W(4),
        .MY_X(1), .MY_Y(1), .CONG_THRESH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .cong_status(cong_status), .err_uturn(err_uturn)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic l, input logic [DW-1:0] d);
        in_valid[p]        = v;
        in_last[p]         = l;
        in_data[p*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] od(input int o);
        return out_data[o*DW +: DW];
    endfunction

    // flit layout: [31:29]=source tag, [7:4]=dest_y, [3:0]=dest_x
    function automatic logic [DW-1:0] mkf(input int src, input int dx, input int dy);
        logic [20:0] r;
        r = 21'($urandom);
        return {3'(src), r, 4'(dy), 4'(dx)};
    endfunction

    // XY dimension-order reference: returns {uturn, port}
    function automatic logic [3:0] ref_route(input int p, input int dx, input int dy);
        int r;
        if (dx > 1)      r = 1;
        else if (dx < 1) r = 2;
        else if (dy > 1) r = 3;
        else if (dy < 1) r = 4;
        else             r = 0;
        if (r == p && p != 0) return {1'b1, 3'd0};
        return {1'b0, 3'(r)};
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = '1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- scoreboard for randomized traffic ----------------
    // entry: {route[2:0], is_head, last, data}
    logic [DW+4:0] sbq [5][$];
    int            cur_src [5];
    bit            mon_en = 1'b0;
    logic [4:0]    exp_err;
    bit            pk_act [5];
    int            pk_len [5];
    int            pk_idx [5];
    int            pk_dx  [5];
    int            pk_dy  [5];
    logic [3:0]    pk_rt  [5];

    logic [DW:0]   m_obs;
    logic [DW+4:0] m_e;
    int            m_src;

    // output monitor: each accepted flit must be the next flit of its source,
    // heads must match the expected port, and packets must not interleave
    always @(negedge clk) begin
        if (mon_en) begin
            for (int o = 0; o < 5; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    m_obs = {out_last[o], out_data[o*DW +: DW]};
                    m_src = int'(m_obs[DW-1 -: 3]);
                    if (m_src < 5 && sbq[m_src].size() > 0) begin
                        m_e = sbq[m_src].pop_front();
                        check("sb_flit", m_obs, m_e[DW:0]);
                        if (cur_src[o] < 0) begin
                            check("sb_head", m_e[DW+1], 1);
                            check("sb_route", o, m_e[DW+4:DW+2]);
                        end else begin
                            check("sb_contig", m_src, cur_src[o]);
                        end
                        cur_src[o] = m_e[DW] ? -1 : m_src;
                    end else begin
                        check("sb_unexpected_src", m_src, 99);
                    end
                end
            end
        end
    end

    task automatic rand_cycle(input bit gen_new, input bit rnd_ready);
        bit acc [5];
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            acc[i] = in_valid[i] && in_ready[i];
            if (acc[i]) begin
                sbq[i].push_back({pk_rt[i][2:0], pk_idx[i] == 0, in_last[i], in_data[i*DW +: DW]});
                if (pk_idx[i] == 0 && pk_rt[i][3]) exp_err[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (acc[i]) begin
                pk_idx[i]++;
                if (pk_idx[i] == pk_len[i]) pk_act[i] = 1'b0;
            end
            if (!pk_act[i] && gen_new && $urandom_range(0, 3) != 0) begin
                pk_act[i] = 1'b1;
                pk_idx[i] = 0;
                pk_len[i] = $urandom_range(1, 4);
                pk_dx[i]  = $urandom_range(0, 2);
                pk_dy[i]  = $urandom_range(0, 2);
                pk_rt[i]  = ref_route(i, pk_dx[i], pk_dy[i]);
            end
            if (pk_act[i] && $urandom_range(0, 7) != 0) begin
                if (pk_idx[i] == 0) drive(i, 1'b1, pk_len[i] == 1, mkf(i, pk_dx[i], pk_dy[i]));
                else drive(i, 1'b1, pk_idx[i] == pk_len[i] - 1, mkf(i, $urandom_range(0, 15), $urandom_range(0, 15)));
            end else begin
                drive(i, 1'b0, 1'b0, '0);
            end
        end
        out_ready = rnd_ready ? (5'($urandom) | 5'($urandom)) : 5'h1F;
    endtask

    // ---------------- directed + random sequence ----------------
    logic [DW-1:0] f [5];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] sd [2];
    logic [DW-1:0] tmp, d0, d3;
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q3 [$];
    logic [2:0]    tsrc;
    int            idx, pulses, exp_src;
    bit            a0, a3, acc0;

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = '1;
        #1;
        check("rst_out_valid", out_valid, 5'h00);
        check("rst_in_ready", in_ready, 5'h1F);
        check("rst_cong", cong_status, 5'h00);
        check("rst_err", err_uturn, 5'h00);
        check("rst_out_data", out_data, '0);

        // ---- L sends 3-flit packet to (3,1): E output, latency 2 ----
        do_reset();
        for (int k = 0; k < 3; k++) f[k] = mkf(0, 3, 1);
        drive(0, 1'b1, 1'b0, f[0]);
        tick();
        check("t2_idle_t1", out_valid[1], 1'b0);
        drive(0, 1'b1, 1'b0, f[1]);
        tick();
        drive(0, 1'b1, 1'b1, f[2]);
        check("t2_v_t2", out_valid[1], 1'b1);
        check("t2_d0", od(1), f[0]);
        check("t2_l0", out_last[1], 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, '0);
        check("t2_d1", od(1), f[1]);
        check("t2_l1", out_last[1], 1'b0);
        tick();
        check("t2_v_t4", out_valid[1], 1'b1);
        check("t2_d2", od(1), f[2]);
        check("t2_l2", out_last[1], 1'b1);
        tick();
        check("t2_done", out_valid, 5'h00);

        // ---- W and S both to local, RR then one bubble, no interleave ----
        do_reset();
        for (int k = 0; k < 2; k++) begin
            wd[k] = mkf(2, 1, 1);
            sd[k] = mkf(4, 1, 1);
        end
        drive(2, 1'b1, 1'b0, wd[0]);
        drive(4, 1'b1, 1'b0, sd[0]);
        tick();
        drive(2, 1'b1, 1'b1, wd[1]);
        drive(4, 1'b1, 1'b1, sd[1]);
        tick();
        drive(2, 1'b0, 1'b0, '0);
        drive(4, 1'b0, 1'b0, '0);
        check("t3_v0", out_valid, 5'h01);
        check("t3_w0", {out_last[0], od(0)}, {1'b0, wd[0]});
        tick();
        check("t3_w1", {out_valid[0], out_last[0], od(0)}, {2'b11, wd[1]});
        tick();
        check("t3_bubble", out_valid, 5'h00);
        tick();
        check("t3_s0", {out_valid[0], out_last[0], od(0)}, {2'b10, sd[0]});
        tick();
        check("t3_s1", {out_valid[0], out_last[0], od(0)}, {2'b11, sd[1]});
        tick();
        check("t3_done", out_valid, 5'h00);

        // ---- E output blocked: FIFO fills at 4, congestion one cycle after count=3 ----
        do_reset();
        out_ready = 5'b11101;
        for (int k = 0; k < 5; k++) f[k] = mkf(0, 3, 1);
        for (int k = 0; k < 4; k++) begin
            check("t4_ready_pre", in_ready[0], 1'b1);
            if (k == 2 || k == 3) check("t4_cong_low", cong_status[0], 1'b0);
            drive(0, 1'b1, 1'b0, f[k]);
            tick();
        end
        drive(0, 1'b1, 1'b1, f[4]);
        check("t4_full", in_ready[0], 1'b0);
        check("t4_cong_high", cong_status[0], 1'b1);
        check("t4_held_data", {out_valid[1], od(1)}, {1'b1, f[0]});
        tick();
        check("t4_still_full", in_ready[0], 1'b0);
        check("t4_held_stable", {out_valid[1], out_last[1], od(1)}, {2'b10, f[0]});
        out_ready = 5'h1F;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            acc0 = in_valid[0] && in_ready[0];
            if (out_valid[1] && idx < 5) begin
                check("t4_drain", {out_last[1], od(1)}, {idx == 4, f[idx]});
                idx++;
            end
            tick();
            if (acc0) drive(0, 1'b0, 1'b0, '0);
        end
        check("t4_count", idx, 5);

        // ---- U-turn on E goes to L and latches sticky error ----
        do_reset();
        f[0] = mkf(1, 2, 1);
        drive(1, 1'b1, 1'b1, f[0]);
        tick();
        drive(1, 1'b0, 1'b0, '0);
        tick();
        check("t5_deliver", {out_valid, out_last[0], od(0)}, {5'h01, 1'b1, f[0]});
        check("t5_err", err_uturn, 5'b00010);
        for (int c = 0; c < 5; c++) tick();
        check("t5_err_sticky", err_uturn, 5'b00010);

        // ---- single-flit packets from L and N to S alternate via RR ----
        do_reset();
        drive(0, 1'b1, 1'b1, mkf(0, 1, 0));
        drive(3, 1'b1, 1'b1, mkf(3, 1, 0));
        exp_src = 0;
        pulses  = 0;
        for (int c = 0; c < 30; c++) begin
            a0 = in_valid[0] && in_ready[0];
            a3 = in_valid[3] && in_ready[3];
            d0 = in_data[0 +: DW];
            d3 = in_data[3*DW +: DW];
            tick();
            if (a0) begin q0.push_back(d0); drive(0, 1'b1, 1'b1, mkf(0, 1, 0)); end
            if (a3) begin q3.push_back(d3); drive(3, 1'b1, 1'b1, mkf(3, 1, 0)); end
            if (out_valid[4]) begin
                pulses++;
                tmp  = od(4);
                tsrc = tmp[DW-1 -: 3];
                check("t6_last", out_last[4], 1'b1);
                check("t6_src", tsrc, exp_src);
                if (tsrc == 3'd0 && q0.size() > 0) check("t6_data", tmp, q0.pop_front());
                else if (tsrc == 3'd3 && q3.size() > 0) check("t6_data", tmp, q3.pop_front());
                exp_src = (exp_src == 0) ? 3 : 0;
            end
        end
        check("t6_pulses", pulses >= 6, 1'b1);

        // ---- randomized traffic against the scoreboard ----
        do_reset();
        exp_err = '0;
        for (int i = 0; i < 5; i++) begin
            cur_src[i] = -1;
            pk_act[i]  = 1'b0;
            pk_idx[i]  = 0;
            pk_len[i]  = 0;
            pk_rt[i]   = '0;
            pk_dx[i]   = 0;
            pk_dy[i]   = 0;
        end
        mon_en = 1'b1;
        for (int c = 0; c < 800; c++) rand_cycle(1'b1, 1'b1);
        for (int c = 0; c < 200; c++) rand_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("rand_leftover", sbq[i].size(), 0);
            check("rand_open_pkt", cur_src[i], -1);
        end
        check("rand_err_uturn", err_uturn, exp_err);

        // ---- reset mid-traffic: immediate clear, no stale flit afterwards ----
        for (int c = 0; c < 40; c++) rand_cycle(1'b1, 1'b1);
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        in_valid = '0;
        #1;
        check("t1_out_valid", out_valid, 5'h00);
        check("t1_in_ready", in_ready, 5'h1F);
        check("t1_cong", cong_status, 5'h00);
        check("t1_err", err_uturn, 5'h00);
        tick();
        rst_n     = 1'b1;
        out_ready = 5'h1F;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t1_no_stale", out_valid, 5'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
